// File: rtl/flp_multiplier_stream.sv
// Pipelined floating-point multiplier with truncate/RNE rounding, status flags and a
// credit-controlled output FIFO so downstream stalls never drop in-flight products.
module flp_multiplier_stream #(
    parameter int unsigned EXPONENT_BITS    = 11,
    parameter int unsigned SIGNIFICANT_BITS = 52,
    parameter int unsigned INTMUL_LAT       = 4,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [EXPONENT_BITS+SIGNIFICANT_BITS:0]   a_i,
    input  logic [EXPONENT_BITS+SIGNIFICANT_BITS:0]   b_i,
    input  logic                                      round_mode_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [EXPONENT_BITS+SIGNIFICANT_BITS:0]   result_o,
    output logic [2:0]                                flags_o
);

    localparam int unsigned E       = EXPONENT_BITS;
    localparam int unsigned M       = SIGNIFICANT_BITS;
    localparam int unsigned W       = 1 + E + M;
    localparam int unsigned MW      = M + 1;
    localparam int unsigned PW      = 2 * MW;
    localparam int unsigned EW      = E + 2;
    localparam int unsigned BIAS    = (1 << (E - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << E) - 1;
    localparam int unsigned FW      = W + 3;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW      = CW + 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          rm;
        logic [EW-1:0] exp;
    } side_t;

    logic accept_c;
    logic wr_c;
    logic pop_c;

    side_t            s0_side_d;
    side_t            s0_side_q;
    logic             s0_vld_q;
    logic [MW-1:0]    s0_ma_q;
    logic [MW-1:0]    s0_mb_q;

    logic [INTMUL_LAT-1:0] mul_vld_q;
    logic [PW-1:0]         mul_prod_q [INTMUL_LAT];
    side_t                 mul_side_q [INTMUL_LAT];

    logic [PW-1:0]          prod_c;
    side_t                  side_c;
    logic                   norm_c;
    logic [PW-2:0]          shifted_c;
    logic [M-1:0]           frac_c;
    logic                   guard_c;
    logic                   sticky_c;
    logic                   inc_c;
    logic [M:0]             frac_r_c;
    logic signed [EW-1:0]   e_c;
    logic [W-1:0]           res_c;
    logic [2:0]             flags_c;

    logic                   rnd_vld_q;
    logic [W-1:0]           rnd_res_q;
    logic [2:0]             rnd_flags_q;

    logic [FW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [FW-1:0]    head_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q;
    logic [W-1:0]     result_q;
    logic [2:0]       flags_q;

    assign accept_c = in_valid_i & in_ready_q;
    assign wr_c     = rnd_vld_q;
    assign pop_c    = out_valid_q & out_ready_i;

    // Operand decode: sign, zero detect and biased exponent sum travel beside the product
    always_comb begin
        s0_side_d      = '0;
        s0_side_d.sign = a_i[W-1] ^ b_i[W-1];
        s0_side_d.zero = (a_i[W-2 -: E] == '0) || (b_i[W-2 -: E] == '0);
        s0_side_d.rm   = round_mode_i;
        s0_side_d.exp  = EW'(a_i[W-2 -: E]) + EW'(b_i[W-2 -: E]) - EW'(BIAS);
    end

    // Normalise, round and classify the product at the multiplier output
    always_comb begin
        prod_c    = mul_prod_q[INTMUL_LAT-1];
        side_c    = mul_side_q[INTMUL_LAT-1];
        norm_c    = prod_c[PW-1];
        shifted_c = norm_c ? prod_c[PW-2:0] : {prod_c[PW-3:0], 1'b0};
        frac_c    = shifted_c[2*M -: M];
        guard_c   = shifted_c[M];
        sticky_c  = |shifted_c[M-1:0];
        inc_c     = side_c.rm & guard_c & (sticky_c | frac_c[0]);
        frac_r_c  = {1'b0, frac_c} + MW'(inc_c);
        e_c       = $signed(side_c.exp + EW'(norm_c) + EW'(frac_r_c[M]));
        res_c     = {side_c.sign, e_c[E-1:0], frac_r_c[M-1:0]};
        flags_c   = {2'b00, guard_c | sticky_c};
        if (side_c.zero) begin
            res_c   = {side_c.sign, (W-1)'(0)};
            flags_c = 3'b000;
        end else if (e_c > $signed(EW'(EXP_MAX))) begin
            res_c   = {side_c.sign, {(W-1){1'b1}}};
            flags_c = 3'b101;
        end else if (e_c <= $signed(EW'(0))) begin
            res_c   = {side_c.sign, (W-1)'(0)};
            flags_c = 3'b011;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit accounting: accepted-but-unwritten plus buffered never exceeds the depth
    always_comb begin
        count_d    = count_q + CW'(wr_c) - CW'(pop_c);
        inflight_d = inflight_q + CW'(accept_c) - CW'(wr_c);
        wr_ptr_d   = wr_c  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        head_d     = (count_q == CW'(pop_c)) ? {rnd_flags_q, rnd_res_q} : mem_q[rd_ptr_d];
        in_ready_d = (SW'(inflight_d) + SW'(count_d)) < SW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_vld_q    <= 1'b0;
            mul_vld_q   <= '0;
            rnd_vld_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s0_vld_q     <= accept_c;
            mul_vld_q[0] <= s0_vld_q;
            for (int unsigned i = 1; i < INTMUL_LAT; i++) begin
                mul_vld_q[i] <= mul_vld_q[i-1];
            end
            rnd_vld_q   <= mul_vld_q[INTMUL_LAT-1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= (count_d != '0);
            if (count_d != '0) begin
                result_q <= head_d[W-1:0];
                flags_q  <= head_d[FW-1:W];
            end
        end
    end

    // Datapath registers carry no reset; only the valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            s0_ma_q   <= {1'b1, a_i[M-1:0]};
            s0_mb_q   <= {1'b1, b_i[M-1:0]};
            s0_side_q <= s0_side_d;
        end
        mul_prod_q[0] <= PW'(s0_ma_q) * PW'(s0_mb_q);
        mul_side_q[0] <= s0_side_q;
        for (int unsigned i = 1; i < INTMUL_LAT; i++) begin
            mul_prod_q[i] <= mul_prod_q[i-1];
            mul_side_q[i] <= mul_side_q[i-1];
        end
        rnd_res_q   <= res_c;
        rnd_flags_q <= flags_c;
        if (wr_c) begin
            mem_q[wr_ptr_q] <= {rnd_flags_q, rnd_res_q};
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;

endmodule

// File: tb/tb_flp_multiplier_stream.sv
// Directed and streaming checks for flp_multiplier_stream with default double-precision parameters.
module tb_flp_multiplier_stream;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        round_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flp_multiplier_stream #(
        .EXPONENT_BITS   (11),
        .SIGNIFICANT_BITS(52),
        .INTMUL_LAT      (4),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .round_mode_i(round_mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .flags_o     (flags)
    );

    // Reference: {flags, result} from remainder-vs-half comparison on a wide product
    function automatic logic [66:0] model(input logic [63:0] x, input logic [63:0] y, input logic rm);
        logic         s;
        int           ea, eb, e, sh;
        logic [127:0] p, keep, rem, half;
        logic         inexact;
        s  = x[63] ^ y[63];
        ea = int'(x[62:52]);
        eb = int'(y[62:52]);
        if (ea == 0 || eb == 0) return {3'b000, s, 63'd0};
        p    = 128'({1'b1, x[51:0]}) * 128'({1'b1, y[51:0]});
        sh   = p[105] ? 53 : 52;
        e    = ea + eb - 1023 + (p[105] ? 1 : 0);
        keep = p >> sh;
        rem  = p & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
        inexact = (rem != 0);
        if (rm && ((rem > half) || (rem == half && keep[0]))) keep = keep + 128'd1;
        if (keep[53]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e > 2047) return {3'b101, s, 63'h7FFF_FFFF_FFFF_FFFF};
        if (e <= 0) return {3'b011, s, 63'd0};
        return {2'b00, inexact, s, 11'(e), keep[51:0]};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [10:0] e;
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      e = 11'd0;
        else if (r == 1) e = 11'($urandom_range(1, 40));
        else if (r == 2) e = 11'($urandom_range(2000, 2047));
        else             e = 11'($urandom_range(700, 1350));
        return {1'($urandom_range(0, 1)), e, 52'({$urandom, $urandom})};
    endfunction

    // Issue one pair with out_ready high; return cycles to out_valid and the head, then drain it
    task automatic run_one(input logic [63:0] av, input logic [63:0] bv, input logic rm,
                           output int lat, output logic [63:0] res, output logic [2:0] fl);
        int guard;
        a = av; b = bv; round_mode = rm; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        fl  = flags;
        if (!out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++;
        if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", flags); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat; logic [63:0] res; logic [2:0] fl;
        run_one(64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, lat, res, fl);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (res !== 64'h4008_0000_0000_0000) begin n_fail++; $display("FAIL basic_result: got %h expected 4008000000000000", res); end
        n_checks++;
        if (fl !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b expected 000", fl); end
    endtask

    task automatic test_tie();
        int lat; logic [63:0] res; logic [2:0] fl;
        run_one(64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, 1'b1, lat, res, fl);
        n_checks++;
        if (res !== 64'h3FF8_0000_0000_0002) begin n_fail++; $display("FAIL tie_rne_result: got %h expected 3ff8000000000002", res); end
        n_checks++;
        if (fl !== 3'b001) begin n_fail++; $display("FAIL tie_rne_flags: got %b expected 001", fl); end
        run_one(64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, 1'b0, lat, res, fl);
        n_checks++;
        if (res !== 64'h3FF8_0000_0000_0001) begin n_fail++; $display("FAIL tie_trunc_result: got %h expected 3ff8000000000001", res); end
        n_checks++;
        if (fl !== 3'b001) begin n_fail++; $display("FAIL tie_trunc_flags: got %b expected 001", fl); end
    endtask

    task automatic test_special();
        logic [63:0] va [3];
        logic [63:0] vb [3];
        logic [63:0] vr [3];
        logic [2:0]  vf [3];
        int lat; logic [63:0] res; logic [2:0] fl;
        va[0] = 64'h7FF0_0000_0000_0000; vb[0] = 64'h4000_0000_0000_0000;
        vr[0] = 64'h7FFF_FFFF_FFFF_FFFF; vf[0] = 3'b101;
        va[1] = 64'h8010_0000_0000_0000; vb[1] = 64'h3FE0_0000_0000_0000;
        vr[1] = 64'h8000_0000_0000_0000; vf[1] = 3'b011;
        va[2] = 64'h0000_0000_0000_0000; vb[2] = 64'h3FF0_0000_0000_0000;
        vr[2] = 64'h0000_0000_0000_0000; vf[2] = 3'b000;
        for (int i = 0; i < 3; i++) begin
            run_one(va[i], vb[i], 1'b1, lat, res, fl);
            n_checks++;
            if (res !== vr[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, vr[i]); end
            n_checks++;
            if (fl !== vf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, fl, vf[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [63:0] exp_r;
        n_acc = 0; out_ready = 1'b0; round_mode = 1'b1; in_valid = 1'b1;
        b = 64'h4000_0000_0000_0000;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a = 64'h3FF0_0000_0000_0000 | 64'(n_acc);
            if (in_ready) n_acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 8) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected 8", n_acc); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_r = 64'h4000_0000_0000_0000 | 64'(i);
            n_checks++;
            if (out_valid !== 1'b1 || result !== exp_r || flags !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_result[%0d]: got valid=%b %h/%b expected valid=1 %h/000", i, out_valid, result, flags, exp_r);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [66:0] q [$];
        logic [66:0] exp_v;
        int sent, got, cyc, gaps, stalls;
        bit started;
        sent = 0; got = 0; cyc = 0; gaps = 0; stalls = 0; started = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0;
        while (got < 100 && cyc < 400) begin
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL thr_unexpected: got %h/%b expected no result", result, flags);
                end else begin
                    exp_v = q.pop_front();
                    if (result !== exp_v[63:0] || flags !== exp_v[66:64]) begin
                        n_fail++;
                        $display("FAIL thr_result[%0d]: got %h/%b expected %h/%b", got, result, flags, exp_v[63:0], exp_v[66:64]);
                    end
                end
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            if (sent < 100) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; stalls++;
                    $display("FAIL thr_in_ready[%0d]: got %b expected 1", sent, in_ready);
                end
                a = rand_op(); b = rand_op(); round_mode = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(model(a, b, round_mode));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 100) begin n_fail++; $display("FAIL thr_count: got %0d expected 100", got); end
        n_checks++;
        if (gaps != 0) begin n_fail++; $display("FAIL thr_gaps: got %0d expected 0", gaps); end
        n_checks++;
        if (stalls != 0) begin n_fail++; $display("FAIL thr_stalls: got %0d expected 0", stalls); end
    endtask

    task automatic test_reset_midstream();
        int guard, seen, lat;
        logic [63:0] res; logic [2:0] fl;
        out_ready = 1'b0; round_mode = 1'b1;
        b = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            a = 64'h3FF0_0000_0000_0000 | 64'(i + 16);
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_buffered: got %b expected 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_during: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_mid_flushed: got %0d results expected 0", seen); end
        run_one(64'hC000_0000_0000_0000, 64'h3FF8_0000_0000_0000, 1'b1, lat, res, fl);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (res !== 64'hC008_0000_0000_0000) begin n_fail++; $display("FAIL rst_mid_result: got %h expected c008000000000000", res); end
        n_checks++;
        if (fl !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", fl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
